// File: rtl/and_not_vector_checker.sv
// Clocked stimulus driver and response checker for a 2-input inhibit gate
// (z = a & ~b). Applies four vectors, each held HOLD_CYCLES clocks, samples
// z_in on the last clock of each hold and reports pass/err_count/fail_mask.
// Optional build macro: AND_NOT_CHK_STOP_ON_FAIL_EN ends a run on the first
// mismatching sample.
module and_not_vector_checker #(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       z_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Stimulus {a,b} for each table index
  function automatic logic [1:0] vec_ab(input logic [1:0] idx);
    case (idx)
      2'd0:    vec_ab = 2'b00;
      2'd1:    vec_ab = 2'b10;
      2'd2:    vec_ab = 2'b11;
      default: vec_ab = 2'b01;
    endcase
  endfunction

  // Expected gate output for each table index (only 1,0 gives 1)
  function automatic logic vec_z(input logic [1:0] idx);
    vec_z = (idx == 2'd1);
  endfunction

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
  logic [1:0]       vec_idx, vec_idx_d;
  logic             a_d, b_d, busy_d, done_d, pass_d;
  logic [2:0]       err_d;
  logic [3:0]       mask_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      vec_idx   <= 2'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_mask <= 4'd0;
    end else begin
      state     <= state_d;
      hold_cnt  <= hold_cnt_d;
      vec_idx   <= vec_idx_d;
      a_out     <= a_d;
      b_out     <= b_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_count <= err_d;
      fail_mask <= mask_d;
    end
  end

  logic       mismatch;
  logic       last_vec;
  logic [2:0] err_n;
  logic [3:0] mask_n;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    hold_cnt_d = hold_cnt;
    vec_idx_d  = vec_idx;
    a_d        = a_out;
    b_d        = b_out;
    busy_d     = busy;
    done_d     = 1'b0;
    pass_d     = pass;
    err_d      = err_count;
    mask_d     = fail_mask;
    mismatch   = 1'b0;
    last_vec   = 1'b0;
    err_n      = err_count;
    mask_n     = fail_mask;

    case (state)
      ST_IDLE: begin
        if (start) begin
          busy_d       = 1'b1;
          vec_idx_d    = 2'd0;
          hold_cnt_d   = '0;
          {a_d, b_d}   = vec_ab(2'd0);
          err_d        = 3'd0;
          mask_d       = 4'd0;
          pass_d       = 1'b0;
          state_d      = ST_APPLY;
        end
      end

      ST_APPLY: begin
        hold_cnt_d = hold_cnt + CNT_W'(1);
        if (hold_cnt == HOLD_LAST) begin
          mismatch = (z_in != vec_z(vec_idx));
          err_n    = err_count + 3'(mismatch);
          mask_n   = fail_mask | (mismatch ? 4'(4'b0001 << vec_idx) : 4'd0);
          err_d    = err_n;
          mask_d   = mask_n;
`ifdef AND_NOT_CHK_STOP_ON_FAIL_EN
          last_vec = (vec_idx == 2'd3) || mismatch;
`else
          last_vec = (vec_idx == 2'd3);
`endif
          if (last_vec) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            a_d     = 1'b0;
            b_d     = 1'b0;
            pass_d  = (err_n == 3'd0);
            state_d = ST_FINISH;
          end else begin
            vec_idx_d  = vec_idx + 2'd1;
            {a_d, b_d} = vec_ab(vec_idx + 2'd1);
            hold_cnt_d = '0;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
